// File: rtl/teclado_matrix_scan.sv
// 4x4 matrix keypad scanner: walks an active-low one-hot row drive, latches the
// code of the first pressed key and pulses data_ready once per press.
module teclado_matrix_scan #(
  parameter int SCAN_DIV = 1
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       data_ready
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       r_reg, r_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [3:0]       row_reg, row_next;
  logic [3:0]       key_reg, key_next;
  logic             dr_reg, dr_next;

  logic             no_key;
  logic [1:0]       col_idx;

  assign no_key = (col == 4'b1111);

  // Priority encoder: the lowest-indexed low column wins.
  always_comb begin
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) col_idx = 2'(i);
    end
  end

  // Row drive is decoded from the next row index so the pins come straight from a register.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row_next[gi] = (r_next != 2'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    div_next   = div_reg;
    key_next   = key_reg;
    dr_next    = 1'b0;
    case (state_reg)
      SCAN: begin
        if (no_key) begin
          if (div_reg == DIV_LAST) begin
            div_next = '0;
            r_next   = r_reg + 2'd1;
          end else begin
            div_next = div_reg + DIV_W'(1);
          end
        end else begin
          key_next   = {r_reg, col_idx};
          dr_next    = 1'b1;
          state_next = HOLD;
          div_next   = '0;
        end
      end
      HOLD: begin
        // Row stays frozen until the key is released, then scanning moves on.
        if (no_key) begin
          state_next = SCAN;
          r_next     = r_reg + 2'd1;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= SCAN;
      r_reg     <= 2'd0;
      div_reg   <= '0;
      row_reg   <= 4'b1110;
      key_reg   <= 4'h0;
      dr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      div_reg   <= div_next;
      row_reg   <= row_next;
      key_reg   <= key_next;
      dr_reg    <= dr_next;
    end
  end

  assign row        = row_reg;
  assign key_code   = key_reg;
  assign data_ready = dr_reg;

endmodule

// File: tb/tb_teclado_matrix_scan.sv
// Bench for teclado_matrix_scan: directed keypad scenarios plus random column
// traffic, checked against a behavioural keypad model (two SCAN_DIV settings).
module tb_teclado_matrix_scan;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col   = 4'b1111;

  logic [3:0] row_a, key_a, row_b, key_b;
  logic       dr_a, dr_b;

  int checks = 0;
  int errors = 0;

  teclado_matrix_scan #(.SCAN_DIV(1)) dut_a (
    .clock(clock), .reset(reset), .row(row_a), .col(col),
    .key_code(key_a), .data_ready(dr_a)
  );

  teclado_matrix_scan #(.SCAN_DIV(3)) dut_b (
    .clock(clock), .reset(reset), .row(row_b), .col(col),
    .key_code(key_b), .data_ready(dr_b)
  );

  always #5 clock = ~clock;

  // Model state per instance: current row, cycles spent on it, key held flag, last key, pulse.
  int   m_row  [2];
  int   m_dwell[2];
  bit   m_held [2];
  int   m_key  [2];
  bit   m_pulse[2];
  int   m_div  [2] = '{1, 3};

  function automatic int lowest_zero(logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input int k);
    if (reset) begin
      m_row[k] = 0; m_dwell[k] = 0; m_held[k] = 0; m_key[k] = 0; m_pulse[k] = 0;
    end else if (m_held[k]) begin
      m_pulse[k] = 0;
      if (col == 4'b1111) begin
        m_held[k] = 0;
        m_row[k]  = (m_row[k] + 1) % 4;
      end
    end else if (col == 4'b1111) begin
      m_pulse[k] = 0;
      m_dwell[k] = m_dwell[k] + 1;
      if (m_dwell[k] == m_div[k]) begin
        m_dwell[k] = 0;
        m_row[k]   = (m_row[k] + 1) % 4;
      end
    end else begin
      m_key[k]   = m_row[k] * 4 + lowest_zero(col);
      m_pulse[k] = 1;
      m_held[k]  = 1;
      m_dwell[k] = 0;
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] one;
    logic [3:0] exp_row;
    one = 4'b0001;
    exp_row = ~(one << m_row[0]);
    check4("a_row", row_a, exp_row);
    check4("a_key", key_a, 4'(m_key[0]));
    check1("a_ready", dr_a, m_pulse[0]);
    exp_row = ~(one << m_row[1]);
    check4("b_row", row_b, exp_row);
    check4("b_key", key_b, 4'(m_key[1]));
    check1("b_ready", dr_b, m_pulse[1]);
  endtask

  // One clock: model sees the same inputs the DUTs sample, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    check_model();
    $display("t=%0t reset=%b col=%b | a: row=%b key=%h rdy=%b | b: row=%b key=%h rdy=%b",
             $time, reset, col, row_a, key_a, dr_a, row_b, key_b, dr_b);
  endtask

  task automatic wait_row_a(input logic [3:0] target);
    int n;
    n = 0;
    while (row_a !== target && n < 16) begin
      tick();
      n++;
    end
    check4("wait_row", row_a, target);
  endtask

  initial begin
    // Reset
    reset = 1'b1; col = 4'b1111;
    tick();
    check4("rst_row", row_a, 4'b1110);
    check4("rst_key", key_a, 4'h0);
    check1("rst_ready", dr_a, 1'b0);
    reset = 1'b0;

    // Idle scan: one row per cycle with wrap-around
    tick(); check4("idle_row1", row_a, 4'b1101);
    tick(); check4("idle_row2", row_a, 4'b1011);
    tick(); check4("idle_row3", row_a, 4'b0111);
    tick(); check4("idle_wrap", row_a, 4'b1110);
    check1("idle_ready", dr_a, 1'b0);

    // One-cycle press on row 1, column 0
    wait_row_a(4'b1101);
    col = 4'b1110;
    tick();
    check4("short_key", key_a, 4'h4);
    check1("short_ready", dr_a, 1'b1);
    col = 4'b1111;
    tick();
    check1("short_ready_off", dr_a, 1'b0);
    check4("short_resume", row_a, 4'b1011);

    // Held press on row 3, column 2
    wait_row_a(4'b0111);
    col = 4'b1011;
    tick();
    check4("held_key", key_a, 4'hE);
    check1("held_ready", dr_a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("held_no_repeat", dr_a, 1'b0);
      check4("held_frozen", row_a, 4'b0111);
    end
    col = 4'b1111;
    tick();
    check4("held_release_row", row_a, 4'b1110);
    check4("held_key_kept", key_a, 4'hE);

    // Multiple low columns: lowest index wins
    wait_row_a(4'b1110);
    col = 4'b0101;
    tick();
    check4("multi_key", key_a, 4'h1);
    col = 4'b1111;
    tick();

    // Reset while a key is held
    wait_row_a(4'b1011);
    col = 4'b1101;
    tick();
    check4("hold_key", key_a, 4'h9);
    tick();
    reset = 1'b1;
    tick();
    check4("hold_rst_row", row_a, 4'b1110);
    check4("hold_rst_key", key_a, 4'h0);
    check1("hold_rst_ready", dr_a, 1'b0);
    reset = 1'b0;
    col = 4'b1111;
    tick();

    // Random column traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) col = 4'b1111;
      else col = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 1'b0;
    col = 4'b1111;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
